// File: rtl/bnn_uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and frame constants.
// Optional macro UART_RX_PARITY_EN adds the PARITY state (8E1 framing).
package bnn_uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/bnn_rx_fifo.sv
// Single-clock receive FIFO with overrun detection and registered clear-to-send.
module bnn_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             overrun,
  output logic             cts
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] CTS_FREE   = CW'(2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             do_pop;
  logic             do_push;
  logic             full;

  assign full    = (count == FULL_COUNT);
  assign do_pop  = (count != '0) && ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign valid   = (count != '0);
  assign rd_data = mem[rd_ptr];

  // Next occupancy, used for both the count register and the cts decision.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage, pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      cts     <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count   <= count_next;
      overrun <= push && full && !do_pop;
      cts     <= (FULL_COUNT - count_next) >= CTS_FREE;
    end
  end

endmodule

// File: rtl/bnn_uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, receive FIFO.
// Default frame is 8N1; defining UART_RX_PARITY_EN selects 8E1 with parity checking.
module bnn_uart_rx
  import bnn_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      uart_rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      uart_cts,
  output logic                      frame_err,
  output logic                      overrun_err,
  output logic                      parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t                 state;
  logic                      rx_s1;
  logic                      rx_s2;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      armed;
  logic                      push;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic parity_q;
  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  // Frame FSM. 'armed' requires a high line before a start bit is accepted,
  // which covers both frame-error recovery and resuming after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      armed     <= 1'b0;
      push      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      parity_q  <= 1'b0;
`endif
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rx_s2) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= ST_START;
            cnt   <= HALF_RELOAD;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            if (!rx_s2) begin
              state   <= ST_DATA;
              cnt     <= BIT_RELOAD;
              bit_idx <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            shreg   <= {rx_s2, shreg[UART_DATA_BITS-1:1]};
            cnt     <= BIT_RELOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == '0) begin
            par_bad <= (rx_s2 != ^shreg);
            cnt     <= BIT_RELOAD;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            armed <= rx_s2;
            if (!rx_s2) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              parity_q <= 1'b1;
`endif
            end else begin
              push <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bnn_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .ready     (rx_ready),
    .rd_data   (rx_data),
    .valid     (rx_valid),
    .overrun   (overrun_err),
    .cts       (uart_cts)
  );

endmodule

// File: tb/tb_bnn_uart_rx.sv
// Self-checking bench for bnn_uart_rx (CLKS_PER_BIT = 16, FIFO_DEPTH = 4).
module tb_bnn_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       uart_cts;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  // Observed activity.
  logic [7:0] got_q[$];
  int valid_cycles = 0;
  int n_frame = 0, n_over = 0, n_par = 0;

  // Reference model: bytes expected at the consumer, model FIFO fill, expected pulse counts.
  logic [7:0] exp_q[$];
  int fill = 0;
  int e_frame = 0, e_over = 0, e_par = 0;

  bnn_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .uart_cts    (uart_cts),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) n_frame++;
      if (overrun_err) n_over++;
      if (parity_err) n_par++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    cycles(CPB);
  endtask

  // Sends one frame and updates the model from the framing rules.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_b);
    uart_rx = 1'b1;
    cycles(4);
    if (!stop_b) e_frame++;
`ifdef UART_RX_PARITY_EN
    else if (par_flip) e_par++;
`endif
    else if (fill == DEPTH) e_over++;
    else begin
      exp_q.push_back(d);
      if (!rx_ready) fill++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(3);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++; if (uart_cts !== 1'b1) begin errors++; $display("FAIL reset_cts: got %b want 1", uart_cts); end
    checks++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
      errors++; $display("FAIL reset_errs: got %b want 000", {frame_err, overrun_err, parity_err});
    end
    rst_n = 1'b1;
    cycles(5);
  endtask

  task automatic test_basic();
    int v0;
    v0 = valid_cycles;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    cycles(10);
    checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 1", valid_cycles - v0); end
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'hA5) begin
      errors++; $display("FAIL basic_data: got size %0d byte %h want 1 byte a5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    checks++; if (n_frame + n_over + n_par !== 0) begin errors++; $display("FAIL basic_errs: got %0d pulses want 0", n_frame + n_over + n_par); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    int v0;
    v0 = valid_cycles;
    uart_rx = 1'b0;
    cycles(5);
    uart_rx = 1'b1;
    cycles(3 * CPB);
    checks++; if (valid_cycles !== v0) begin errors++; $display("FAIL glitch_valid: got %0d cycles want %0d", valid_cycles, v0); end
    checks++; if (n_frame !== e_frame) begin errors++; $display("FAIL glitch_frame_err: got %0d want %0d", n_frame, e_frame); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b0);
    cycles(CPB);
    checks++; if (n_frame !== e_frame) begin errors++; $display("FAIL frame_err_count: got %0d want %0d", n_frame, e_frame); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL frame_err_push: got %0d bytes want 0", got_q.size()); end
    send_frame(8'h55, 1'b1, 1'b0);
    cycles(10);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL frame_err_next_size: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL frame_err_next_byte%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overrun();
    int t;
    rx_ready = 1'b0;
    cycles(2);
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, 1'b0);
      checks++; if (uart_cts !== ((DEPTH - fill) >= 2)) begin
        errors++; $display("FAIL overrun_cts_b%0d: got %b want %b", b, uart_cts, (DEPTH - fill) >= 2);
      end
      checks++; if (rx_data !== exp_q[0]) begin errors++; $display("FAIL overrun_head_b%0d: got %h want %h", b, rx_data, exp_q[0]); end
    end
    checks++; if (n_over !== e_over) begin errors++; $display("FAIL overrun_count: got %0d want %0d", n_over, e_over); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL overrun_stall_pop: got %0d pops want 0", got_q.size()); end
    rx_ready = 1'b1;
    t = 0;
    while (rx_valid && t < 50) begin cycles(1); t++; end
    checks++; if (t >= 50) begin errors++; $display("FAIL overrun_drain_timeout: got %0d cycles want <50", t); end
    fill = 0;
    cycles(4);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL overrun_drain_size: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL overrun_drain_byte%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (uart_cts !== 1'b1) begin errors++; $display("FAIL overrun_cts_after_drain: got %b want 1", uart_cts); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    cycles(CPB);
    checks++; if (n_par !== e_par) begin errors++; $display("FAIL parity_err_count: got %0d want %0d", n_par, e_par); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL parity_bad_push: got %0d bytes want 0", got_q.size()); end
    send_frame(8'h07, 1'b1, 1'b0);
    cycles(10);
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h07) begin
      errors++; $display("FAIL parity_good_byte: got size %0d want 1 byte 07", got_q.size());
    end
    got_q.delete(); exp_q.delete();
`endif
    checks++; if (n_par !== e_par) begin errors++; $display("FAIL parity_pulses: got %0d want %0d", n_par, e_par); end
  endtask

  task automatic test_reset_midframe();
    int v0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    v0 = valid_cycles;
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    drive_bit(1'b0);
`endif
    drive_bit(1'b1);
    cycles(2 * CPB);
    checks++; if (valid_cycles !== v0 || got_q.size() !== 0) begin
      errors++; $display("FAIL midreset_output: got %0d valid cycles want 0", valid_cycles - v0);
    end
    send_frame(8'h12, 1'b1, 1'b0);
    cycles(10);
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h12) begin
      errors++; $display("FAIL midreset_next: got size %0d want 1 byte 12", got_q.size());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      cycles($urandom_range(0, 20));
    end
    cycles(10);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_size: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL random_byte%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (n_frame !== e_frame || n_over !== e_over) begin
      errors++; $display("FAIL random_errs: got frame %0d over %0d want %0d %0d", n_frame, n_over, e_frame, e_over);
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_parity();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_uart_rx.md
BNN_UART_RX -- requirements
Module: bnn_uart_rx

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low (port rst_n); clock port clk.
REQ-002 Parameter CLKS_PER_BIT SHALL default to 434 and set the clk cycles per UART bit (minimum 8).
REQ-003 Parameter FIFO_DEPTH SHALL default to 4 and set the receive FIFO entry count (power of two, minimum 2).
REQ-004 Ports SHALL be:
- clk, input, 1: system clock.
- rst_n, input, 1: async active-low reset.
- uart_rx, input, 1: serial line, idle high, asynchronous.
- rx_data, output, 8: FIFO head byte.
- rx_valid, output, 1: FIFO non-empty.
- rx_ready, input, 1: consumer accepts head.
- uart_cts, output, 1: high = sender may transmit.
- frame_err, output, 1: one-cycle pulse on bad stop bit.
- overrun_err, output, 1: one-cycle pulse on byte dropped because FIFO full.
- parity_err, output, 1: one-cycle pulse on parity mismatch (tied 0 without the macro).

Function
REQ-005 uart_rx SHALL pass through a 2-flop synchronizer before any use; all sampling SHALL use the synchronized value.
REQ-006 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-007 IDLE: on synchronized rx = 0, go to START with bit counter loaded to CLKS_PER_BIT/2 - 1.
REQ-008 START: at counter expiry (mid start bit), go to DATA if rx = 0, else to IDLE with no output (glitch reject).
REQ-009 DATA: sample every CLKS_PER_BIT cycles, LSB first, exactly 8 bits, then go to PARITY or STOP.
REQ-010 STOP: at mid stop bit, rx = 1 SHALL push the byte; rx = 0 SHALL pulse frame_err, discard the byte, and wait in IDLE until rx = 1 is sampled.
REQ-011 rx_valid SHALL assert on the clock edge after a push into an empty FIFO.
REQ-012 A pop SHALL occur on any edge with rx_valid && rx_ready.
REQ-013 rx_data SHALL stay stable while rx_valid && !rx_ready.
REQ-014 A push while full SHALL drop the new byte and pulse overrun_err, leaving contents unchanged.
REQ-015 A push and pop in the same cycle while full SHALL both succeed with count unchanged and no overrun_err.
REQ-016 uart_cts SHALL be high when at least 2 entries are free, and low otherwise; it SHALL be registered.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-018 On rst_n low: FSM = IDLE, synchronizer flops = 1, FIFO empty, rx_valid = 0, rx_data = 0, uart_cts = 1, all error pulses = 0.
REQ-019 Reset mid-frame SHALL abandon the partial byte.
REQ-020 After reset release, reception SHALL resume only on a new falling edge.

Configuration
REQ-021 With UART_RX_PARITY_EN defined, frame SHALL be 8E1: PARITY state samples one bit; if it differs from XOR of the data, the block pulses parity_err in STOP and drops the byte (frame_err takes precedence if both).
REQ-022 Without UART_RX_PARITY_EN, frame SHALL be 8N1, the PARITY state SHALL not exist, and parity_err SHALL be constant 0.

Structure
REQ-023 Package bnn_uart_pkg SHALL hold the FSM state enum, UART_DATA_BITS = 8, and the default CLKS_PER_BIT constant.
REQ-024 The FIFO SHALL be a separate sub-module, bnn_rx_fifo (synchronous, single clock, parameterised depth/width), instantiated once.

Verification (CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
REQ-025 The bench SHALL cover these scenarios:
- Send 0xA5 8N1 with rx_ready = 1 -> one rx_valid cycle, rx_data = 0xA5, no error pulses.
- Low glitch of 5 cycles on an idle line -> FSM returns to IDLE, rx_valid stays 0.
- Send 0x3C with stop bit = 0 -> one frame_err pulse, no push, next valid frame 0x55 received correctly.
- Send 0x01..0x05 with rx_ready = 0 -> uart_cts low after the 3rd byte, overrun_err pulse on the 5th byte; drain yields 0x01, 0x02, 0x03, 0x04.
- With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err pulse and no push; 0x07 with parity bit 1 -> accepted.
- Assert rst_n low after the 4th data bit of 0xFF -> after release, no output; next frame 0x12 received intact.
